// File: rtl/fracsec_tracker.sv
// Second-boundary tracker for a free-running 64-bit fractional-second count:
// PPS pulse, whole-seconds counter, handshaked time snapshot and stall flags.
module fracsec_tracker #(
  parameter int SECW   = 32,
  parameter int MAXGAP = 16
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_sync,
  input  logic [63:0]     i_frac,
  input  logic            i_snap_req,
  input  logic            i_snap_ack,
  input  logic            i_clr_lost,
  output logic            o_pps,
  output logic [SECW-1:0] o_seconds,
  output logic            o_snap_valid,
  output logic [SECW-1:0] o_snap_sec,
  output logic [63:0]     o_snap_frac,
  output logic            o_lost,
  output logic            o_overrun
);

  localparam logic [7:0] GAP_MAX  = 8'(MAXGAP);
  localparam logic [7:0] GAP_LAST = 8'(MAXGAP - 1);

  typedef enum logic [1:0] {
    SNAP_IDLE,
    SNAP_ARMED,
    SNAP_HOLD
  } snap_state_t;

  function automatic logic [7:0] gap_sat_inc(input logic [7:0] v);
    return (v >= GAP_MAX) ? GAP_MAX : v + 8'd1;
  endfunction

  function automatic logic [SECW-1:0] sec_step(input logic [SECW-1:0] s, input logic inc);
    return s + SECW'(inc);
  endfunction

  snap_state_t     state, state_nxt;
  logic [63:0]     r_last;
  logic            r_primed;
  logic [7:0]      gap;
  logic            wrap;
  logic [SECW-1:0] sec_next;
  logic            capture;
  logic            overrun_set;
  logic            lost_set;

  // Wrap is a strict unsigned decrease between consecutive samples.
  always_comb begin
    wrap     = i_sync && r_primed && (i_frac < r_last);
    sec_next = sec_step(o_seconds, wrap);
    lost_set = r_primed && !i_sync && (gap == GAP_LAST);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_last    <= '0;
      r_primed  <= 1'b0;
      gap       <= '0;
      o_seconds <= '0;
      o_pps     <= 1'b0;
    end else begin
      o_pps     <= wrap;
      o_seconds <= sec_next;
      if (i_sync) begin
        r_last   <= i_frac;
        r_primed <= 1'b1;
        gap      <= '0;
      end else if (r_primed) begin
        gap <= gap_sat_inc(gap);
      end
    end
  end

  // Snapshot sequencing: a request arms, the next sync captures, ack releases.
  always_comb begin
    state_nxt   = state;
    capture     = 1'b0;
    overrun_set = 1'b0;
    case (state)
      SNAP_IDLE: begin
        if (i_snap_req) state_nxt = SNAP_ARMED;
      end
      SNAP_ARMED: begin
        if (i_sync) begin
          capture   = 1'b1;
          state_nxt = SNAP_HOLD;
        end
      end
      SNAP_HOLD: begin
        if (i_snap_ack) begin
          state_nxt = i_snap_req ? SNAP_ARMED : SNAP_IDLE;
        end else if (i_snap_req) begin
          overrun_set = 1'b1;
        end
      end
      default: state_nxt = SNAP_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= SNAP_IDLE;
    else         state <= state_nxt;
  end

  assign o_snap_valid = (state == SNAP_HOLD);

  // Captured seconds include any increment produced by the capturing sample.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_snap_sec  <= '0;
      o_snap_frac <= '0;
    end else if (capture) begin
      o_snap_sec  <= sec_next;
      o_snap_frac <= i_frac;
    end
  end

  // Sticky flags: a set event in the same cycle as a clear wins.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_lost    <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_lost    <= lost_set    | (o_lost    & ~i_clr_lost);
      o_overrun <= overrun_set | (o_overrun & ~i_clr_lost);
    end
  end

endmodule

// File: tb/tb_fracsec_tracker.sv
// Bench for fracsec_tracker: directed steps followed by random traffic,
// all compared each cycle against a behavioural time-keeping model.
module tb_fracsec_tracker;
  localparam int SECW   = 32;
  localparam int MAXGAP = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            sync = 1'b0;
  logic [63:0]     frac = '0;
  logic            req = 1'b0;
  logic            ack = 1'b0;
  logic            clr = 1'b0;
  logic            pps;
  logic [SECW-1:0] seconds;
  logic            snap_valid;
  logic [SECW-1:0] snap_sec;
  logic [63:0]     snap_frac;
  logic            lost;
  logic            overrun;

  fracsec_tracker #(.SECW(SECW), .MAXGAP(MAXGAP)) dut (
    .i_clk(clk), .i_reset(rst), .i_sync(sync), .i_frac(frac),
    .i_snap_req(req), .i_snap_ack(ack), .i_clr_lost(clr),
    .o_pps(pps), .o_seconds(seconds), .o_snap_valid(snap_valid),
    .o_snap_sec(snap_sec), .o_snap_frac(snap_frac),
    .o_lost(lost), .o_overrun(overrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: time as "last sample seen", clocks since last sync,
  // and a request/held pair describing the snapshot handshake.
  bit              m_primed;
  logic [63:0]     m_last;
  logic [SECW-1:0] m_sec;
  bit              m_pps;
  int              m_age;
  bit              m_want;
  bit              m_held;
  logic [SECW-1:0] m_ssec;
  logic [63:0]     m_sfrac;
  bit              m_lost;
  bit              m_ovr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_primed = 0; m_last = '0; m_sec = '0; m_pps = 0; m_age = 0;
    m_want = 0; m_held = 0; m_ssec = '0; m_sfrac = '0; m_lost = 0; m_ovr = 0;
  endtask

  task automatic model_step(input bit s, input logic [63:0] f, input bit rq, input bit ak,
                            input bit cl);
    bit w, lost_set, ovr_set;
    logic [SECW-1:0] sec_new;
    w = m_primed && s && (f < m_last);
    sec_new = m_sec + SECW'(w);
    lost_set = 0;
    ovr_set = 0;
    if (s) begin
      m_last = f; m_primed = 1; m_age = 0;
    end else if (m_primed) begin
      m_age++;
      if (m_age == MAXGAP) lost_set = 1;
    end
    if (m_held) begin
      if (ak) begin m_held = 0; m_want = rq; end
      else if (rq) ovr_set = 1;
    end else if (m_want) begin
      if (s) begin m_ssec = sec_new; m_sfrac = f; m_held = 1; m_want = 0; end
    end else begin
      m_want = rq;
    end
    m_pps = w;
    m_sec = sec_new;
    m_lost = lost_set | (m_lost & ~cl);
    m_ovr  = ovr_set  | (m_ovr  & ~cl);
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ":pps"},        64'(pps),        64'(m_pps));
    chk({ctx, ":seconds"},    64'(seconds),    64'(m_sec));
    chk({ctx, ":snap_valid"}, 64'(snap_valid), 64'(m_held));
    chk({ctx, ":snap_sec"},   64'(snap_sec),   64'(m_ssec));
    chk({ctx, ":snap_frac"},  snap_frac,       m_sfrac);
    chk({ctx, ":lost"},       64'(lost),       64'(m_lost));
    chk({ctx, ":overrun"},    64'(overrun),    64'(m_ovr));
  endtask

  task automatic cycle(input string ctx, input bit s, input logic [63:0] f,
                       input bit rq, input bit ak, input bit cl);
    sync = s; frac = f; req = rq; ack = ak; clr = cl;
    @(posedge clk);
    model_step(s, f, rq, ak, cl);
    #1;
    check_all(ctx);
    sync = 0; req = 0; ack = 0; clr = 0;
  endtask

  // Reset is raised between clock edges; outputs must clear without an edge.
  task automatic do_reset(input string ctx);
    sync = 0; req = 0; ack = 0; clr = 0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all(ctx);
    @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  initial begin
    int pulses;
    int guard;
    logic [63:0] f;
    logic [63:0] prev_f;

    do_reset("reset");

    // Priming: the first sample never produces a pulse.
    cycle("prime1", 1, 64'hFFFF_0000_0000_0000, 0, 0, 0);
    chk("prime_no_pps", 64'(pps), 64'd0);
    cycle("prime2", 1, 64'h0000_1000_0000_0000, 0, 0, 0);
    chk("prime_pps", 64'(pps), 64'd1);
    chk("prime_seconds", 64'(seconds), 64'd1);
    cycle("prime_idle", 0, 64'd0, 0, 0, 0);
    chk("prime_pps_one_cycle", 64'(pps), 64'd0);

    // Steady quarter-second stepping.
    do_reset("reset2");
    pulses = 0;
    f = '0;
    for (int i = 0; i < 12; i++) begin
      cycle("steady", 1, f, 0, 0, 0);
      if (pps === 1'b1) pulses++;
      f = f + 64'h4000_0000_0000_0000;
    end
    chk("steady_pulses", 64'(pulses), 64'd2);
    chk("steady_seconds", 64'(seconds), 64'd2);
    cycle("equal", 1, 64'hC000_0000_0000_0000, 0, 0, 0);
    chk("equal_no_pps", 64'(pps), 64'd0);

    // Walk seconds to 5, ending on a small fraction.
    guard = 0;
    while (m_sec != 5 && guard < 20) begin
      cycle("walk_hi", 1, 64'h8000_0000_0000_0000, 0, 0, 0);
      cycle("walk_lo", 1, 64'h1, 0, 0, 0);
      guard++;
    end
    chk("sec_before_snap", 64'(seconds), 64'd5);

    // Snapshot on a plain sample, held while unacknowledged.
    cycle("snap_req", 0, 64'd0, 1, 0, 0);
    chk("armed_not_valid", 64'(snap_valid), 64'd0);
    cycle("snap_cap", 1, 64'h1234, 0, 0, 0);
    chk("snap_valid", 64'(snap_valid), 64'd1);
    chk("snap_sec5", 64'(snap_sec), 64'd5);
    chk("snap_frac", snap_frac, 64'h1234);
    for (int i = 0; i < 10; i++) begin
      cycle("snap_hold", 1, 64'h2000 + 64'(i) * 64'h100, 0, 0, 0);
      chk("snap_hold_frac", snap_frac, 64'h1234);
    end
    cycle("snap_ack", 0, 64'd0, 0, 1, 0);
    chk("snap_released", 64'(snap_valid), 64'd0);

    // Capture on a wrapping sample sees the incremented seconds.
    cycle("wrap_req", 0, 64'd0, 1, 0, 0);
    cycle("wrap_cap", 1, 64'h10, 0, 0, 0);
    chk("wrap_cap_pps", 64'(pps), 64'd1);
    chk("wrap_cap_valid", 64'(snap_valid), 64'd1);
    chk("wrap_cap_sec", 64'(snap_sec), 64'd6);

    // Overrun, then ack+req together re-arms without overrun.
    cycle("ovr_req", 0, 64'd0, 1, 0, 0);
    chk("overrun_set", 64'(overrun), 64'd1);
    cycle("ack_req", 0, 64'd0, 1, 1, 0);
    chk("ack_req_valid", 64'(snap_valid), 64'd0);
    cycle("rearm_cap", 1, 64'h20, 0, 0, 0);
    chk("rearm_valid", 64'(snap_valid), 64'd1);
    chk("rearm_frac", snap_frac, 64'h20);

    // Sync gap: lost sets exactly on the MAXGAP-th silent clock.
    for (int i = 0; i < MAXGAP - 1; i++) cycle("gap", 0, 64'd0, 0, 0, 0);
    chk("lost_not_yet", 64'(lost), 64'd0);
    cycle("gap_last", 0, 64'd0, 0, 0, 0);
    chk("lost_set", 64'(lost), 64'd1);
    cycle("clr", 0, 64'd0, 0, 0, 1);
    chk("clr_lost", 64'(lost), 64'd0);
    chk("clr_overrun", 64'(overrun), 64'd0);

    // Asynchronous reset while a snapshot is held.
    chk("hold_before_rst", 64'(snap_valid), 64'd1);
    do_reset("reset_mid_hold");
    cycle("reprime", 1, 64'h5, 0, 0, 0);
    chk("reprime_no_pps", 64'(pps), 64'd0);
    cycle("reprime_wrap", 1, 64'h3, 0, 0, 0);
    chk("reprime_wrap_pps", 64'(pps), 64'd1);

    // Random traffic with occasional long stalls.
    prev_f = 64'h3;
    for (int i = 0; i < 800; i++) begin
      bit s, rq, ak, cl;
      if (i % 160 == 80) begin
        for (int k = 0; k < MAXGAP + 4; k++) cycle("rnd_stall", 0, 64'd0, 0, 0, 0);
      end
      s  = ($urandom_range(0, 3) != 0);
      rq = ($urandom_range(0, 7) == 0);
      ak = ($urandom_range(0, 5) == 0);
      cl = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) f = prev_f;
      else f = {$urandom, $urandom};
      if (s) prev_f = f;
      cycle("rnd", s, f, rq, ak, cl);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fracsec_tracker.md
Name: fracsec_tracker

Overview:
- Consumes the registered 64-bit fractional-second count and its sync strobe from the pipelined 64-bit adder stage.
- Detects second-boundary wrap-around, emits a one-cycle PPS pulse and keeps a whole-seconds counter.
- Provides a request/valid/ack snapshot port that captures the {seconds, fraction} time on a sample boundary.
- Flags lost sync strobes, i.e. an adder pipeline stall.

Parameters:
- SECW, 32, width of whole-seconds counter (1..64).
- MAXGAP, 16, maximum clocks permitted between consecutive i_sync strobes before o_lost sets (2..255).

Ports:
- i_clk  input  1  system clock.
- i_reset  input  1  asynchronous, active-high reset.
- i_sync  input  1  sample strobe; i_frac valid this cycle.
- i_frac  input  64  fractional-second count (unsigned, full-scale = 1 s).
- i_snap_req  input  1  one-cycle snapshot request.
- i_snap_ack  input  1  consumer accepts snapshot.
- i_clr_lost  input  1  clears o_lost and o_overrun.
- o_pps  output  1  one-cycle pulse at each second boundary.
- o_seconds  output  SECW  whole-seconds count.
- o_snap_valid  output  1  snapshot held.
- o_snap_sec  output  SECW  captured seconds.
- o_snap_frac  output  64  captured fraction.
- o_lost  output  1  sticky: sync gap exceeded MAXGAP.
- o_overrun  output  1  sticky: request arrived while snapshot pending.

Behaviour:
- Reset (async, immediate): all outputs 0; r_last=0; r_primed=0; gap counter=0; snapshot FSM=IDLE. Reset mid-operation discards any pending or held snapshot.
- Priming: the first i_sync after reset loads r_last=i_frac and sets r_primed. No PPS and no seconds increment on this sample.
- Wrap detection, on i_sync when primed:
  - wrap = (i_frac < r_last), unsigned 64-bit compare. Equal is not a wrap.
  - r_last <= i_frac on every i_sync.
  - On wrap: o_pps=1 for exactly the next cycle; o_seconds increments on the same edge.
  - o_seconds wraps from all-ones to 0.
  - i_frac is ignored when i_sync=0.
- Gap monitor:
  - Counter clears on i_sync, otherwise increments, saturating at MAXGAP.
  - The clock the counter reaches MAXGAP without i_sync, o_lost <= 1. Inactive until primed.
- Snapshot FSM:
  - IDLE: i_snap_req -> ARMED.
  - ARMED: on next i_sync -> HOLD. The captured values are post-update: o_snap_frac=i_frac, o_snap_sec=seconds including any increment caused by this same sample. o_snap_valid=1 from the cycle after capture.
  - HOLD: o_snap_* stable while valid. i_snap_ack -> IDLE, o_snap_valid=0 next cycle.
  - i_snap_req in the same cycle as i_sync in IDLE: goes to ARMED only, capturing on the following sync, so capture is always strictly after the request.
  - i_snap_req while ARMED: absorbed, no effect.
  - i_snap_req while HOLD and not acked that cycle: ignored, o_overrun <= 1.
  - i_snap_ack while not HOLD: ignored.
  - ack and req in the same HOLD cycle: -> ARMED, no overrun.
- i_clr_lost clears both sticky flags. A simultaneous set event wins.
- Latency: i_sync sample to o_pps/o_seconds = 1 clock; to o_snap_valid = 1 clock after the capturing sync.

Test Plan:
- Priming/no false PPS: reset, then sync with frac=0xFFFF_0000_0000_0000, then frac=0x0000_1000_0000_0000 -> no PPS on first sample; o_pps one cycle after second sample; o_seconds=1.
- Steady count: syncs every cycle, frac stepping +0x4000_0000_0000_0000 from 0 for 12 samples -> 2 PPS pulses (4th→5th and 8th→9th samples wrap); o_seconds=2; equal-value repeat gives no pulse.
- Snapshot: seconds=5; req; next sync frac=0x1234 -> o_snap_valid next cycle with sec=5, frac=0x1234; held 10 cycles unchanged; ack -> valid low next cycle.
- Capture on wrap sample: arm, then wrapping sync -> o_snap_sec equals incremented seconds, concurrent with o_pps.
- Overrun/lost: req during HOLD -> o_overrun=1. With MAXGAP=16, withhold sync 16 clocks -> o_lost=1 exactly at count 16. i_clr_lost -> both 0.
- Async reset mid-HOLD, asserted between clock edges -> all outputs 0 immediately; next sync re-primes without PPS.
